// File: rtl/axis_dest_tagger.sv
// Tags each AXI4-Stream frame with a tdest from a first-beat header-field rule lookup; one register stage plus skid.
// Optional per-rule hit / miss counters are enabled by defining AXIS_TAG_STATS_EN.
module axis_dest_tagger #(
  parameter int DATA_WIDTH   = 512,
  parameter int KEEP_WIDTH   = DATA_WIDTH/8,
  parameter int USER_WIDTH   = 1,
  parameter int DEST_WIDTH   = 2,
  parameter int RULE_COUNT   = 4,
  parameter int FIELD_OFFSET = 96,
  parameter int FIELD_WIDTH  = 16,
  parameter int DEFAULT_DEST = 0,
  localparam int ADDR_WIDTH  = (RULE_COUNT > 1) ? $clog2(RULE_COUNT) : 1
) (
  input  logic                          clk,
  input  logic                          rst_n,

  input  logic [DATA_WIDTH-1:0]         s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0]         s_axis_tkeep,
  input  logic                          s_axis_tvalid,
  output logic                          s_axis_tready,
  input  logic                          s_axis_tlast,
  input  logic [USER_WIDTH-1:0]         s_axis_tuser,

  output logic [DATA_WIDTH-1:0]         m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]         m_axis_tkeep,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tlast,
  output logic [USER_WIDTH-1:0]         m_axis_tuser,
  output logic [DEST_WIDTH-1:0]         m_axis_tdest,

`ifdef AXIS_TAG_STATS_EN
  input  logic [$clog2(RULE_COUNT+1)-1:0] stat_sel,
  input  logic                          stat_clr,
  output logic [31:0]                   stat_count,
`endif

  input  logic                          cfg_wr_en,
  input  logic [ADDR_WIDTH-1:0]         cfg_addr,
  input  logic                          cfg_valid,
  input  logic [FIELD_WIDTH-1:0]        cfg_match,
  input  logic [FIELD_WIDTH-1:0]        cfg_mask,
  input  logic [DEST_WIDTH-1:0]         cfg_dest
);

  typedef enum logic {IDLE, IN_FRAME} state_t;
  state_t state_q, state_d;

  logic [RULE_COUNT-1:0]  rule_vld;
  logic [FIELD_WIDTH-1:0] rule_match [RULE_COUNT];
  logic [FIELD_WIDTH-1:0] rule_mask  [RULE_COUNT];
  logic [DEST_WIDTH-1:0]  rule_dest  [RULE_COUNT];

  logic [FIELD_WIDTH-1:0] field;
  logic [RULE_COUNT-1:0]  hit;
  logic [DEST_WIDTH-1:0]  lk_dest;
  logic [DEST_WIDTH-1:0]  dest_reg;
  logic [DEST_WIDTH-1:0]  beat_dest;
  logic                   s_xfer;
  logic                   first_beat;

  logic [DATA_WIDTH-1:0]  out_data, tmp_data;
  logic [KEEP_WIDTH-1:0]  out_keep, tmp_keep;
  logic                   out_last, tmp_last;
  logic [USER_WIDTH-1:0]  out_user, tmp_user;
  logic [DEST_WIDTH-1:0]  out_dest, tmp_dest;
  logic                   out_vld, tmp_vld, in_rdy;
  logic                   out_vld_d, tmp_vld_d, in_rdy_d;
  logic                   load_out_in, load_out_tmp, load_tmp;

  assign s_axis_tready = in_rdy;
  assign m_axis_tvalid = out_vld;
  assign m_axis_tdata  = out_data;
  assign m_axis_tkeep  = out_keep;
  assign m_axis_tlast  = out_last;
  assign m_axis_tuser  = out_user;
  assign m_axis_tdest  = out_dest;

  assign s_xfer     = s_axis_tvalid && in_rdy;
  assign first_beat = (state_q == IDLE);
  assign field      = s_axis_tdata[FIELD_OFFSET +: FIELD_WIDTH];

  always_comb begin
    for (int i = 0; i < RULE_COUNT; i++) begin
      hit[i] = rule_vld[i] && (((field ^ rule_match[i]) & rule_mask[i]) == '0);
    end
  end

  // Scan from the top so the lowest hitting index is the last one assigned.
  always_comb begin
    lk_dest = DEST_WIDTH'(DEFAULT_DEST);
    for (int i = RULE_COUNT-1; i >= 0; i--) begin
      if (hit[i]) lk_dest = rule_dest[i];
    end
  end

  assign beat_dest = first_beat ? lk_dest : dest_reg;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (s_xfer && !s_axis_tlast) state_d = IN_FRAME;
      IN_FRAME: if (s_xfer && s_axis_tlast)  state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    out_vld_d    = out_vld;
    tmp_vld_d    = tmp_vld;
    load_out_in  = 1'b0;
    load_out_tmp = 1'b0;
    load_tmp     = 1'b0;
    if (in_rdy) begin
      if (m_axis_tready || !out_vld) begin
        out_vld_d   = s_axis_tvalid;
        load_out_in = 1'b1;
      end else begin
        tmp_vld_d = s_axis_tvalid;
        load_tmp  = 1'b1;
      end
    end else if (m_axis_tready) begin
      out_vld_d    = tmp_vld;
      tmp_vld_d    = 1'b0;
      load_out_tmp = 1'b1;
    end
    in_rdy_d = m_axis_tready || !tmp_vld_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      out_vld  <= 1'b0;
      tmp_vld  <= 1'b0;
      in_rdy   <= 1'b0;
      rule_vld <= '0;
      dest_reg <= '0;
    end else begin
      state_q <= state_d;
      out_vld <= out_vld_d;
      tmp_vld <= tmp_vld_d;
      in_rdy  <= in_rdy_d;
      if (s_xfer && first_beat) dest_reg <= lk_dest;
      if (cfg_wr_en && int'(cfg_addr) < RULE_COUNT) rule_vld[cfg_addr] <= cfg_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (cfg_wr_en && int'(cfg_addr) < RULE_COUNT) begin
      rule_match[cfg_addr] <= cfg_match;
      rule_mask[cfg_addr]  <= cfg_mask;
      rule_dest[cfg_addr]  <= cfg_dest;
    end
  end

  // Payload carries no reset: it is only observed while its valid flag is set.
  always_ff @(posedge clk) begin
    if (load_out_in) begin
      out_data <= s_axis_tdata;
      out_keep <= s_axis_tkeep;
      out_last <= s_axis_tlast;
      out_user <= s_axis_tuser;
      out_dest <= beat_dest;
    end else if (load_out_tmp) begin
      out_data <= tmp_data;
      out_keep <= tmp_keep;
      out_last <= tmp_last;
      out_user <= tmp_user;
      out_dest <= tmp_dest;
    end
    if (load_tmp) begin
      tmp_data <= s_axis_tdata;
      tmp_keep <= s_axis_tkeep;
      tmp_last <= s_axis_tlast;
      tmp_user <= s_axis_tuser;
      tmp_dest <= beat_dest;
    end
  end

`ifdef AXIS_TAG_STATS_EN
  logic [31:0]                   stat_cnt [RULE_COUNT+1];
  logic [$clog2(RULE_COUNT+1)-1:0] stat_idx;

  // Slot RULE_COUNT is the miss counter.
  always_comb begin
    stat_idx = ($clog2(RULE_COUNT+1))'(RULE_COUNT);
    for (int i = RULE_COUNT-1; i >= 0; i--) begin
      if (hit[i]) stat_idx = ($clog2(RULE_COUNT+1))'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || stat_clr) begin
      for (int i = 0; i <= RULE_COUNT; i++) stat_cnt[i] <= '0;
    end else if (s_xfer && first_beat && stat_cnt[stat_idx] != 32'hFFFF_FFFF) begin
      stat_cnt[stat_idx] <= stat_cnt[stat_idx] + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) stat_count <= '0;
    else if (int'(stat_sel) <= RULE_COUNT) stat_count <= stat_cnt[stat_sel];
    else stat_count <= '0;
  end
`endif

endmodule

// File: tb/tb_axis_dest_tagger.sv
// Randomized scoreboard bench for axis_dest_tagger: a frame-level reference model predicts every output beat and its tdest.
module tb_axis_dest_tagger;
  localparam int DW = 512, KW = 64, UW = 1, DESTW = 2, RC = 4, FO = 96, FW = 16, AW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic [DW-1:0] s_axis_tdata;
  logic [KW-1:0] s_axis_tkeep;
  logic s_axis_tvalid, s_axis_tready, s_axis_tlast;
  logic [UW-1:0] s_axis_tuser;
  logic [DW-1:0] m_axis_tdata;
  logic [KW-1:0] m_axis_tkeep;
  logic m_axis_tvalid, m_axis_tready, m_axis_tlast;
  logic [UW-1:0] m_axis_tuser;
  logic [DESTW-1:0] m_axis_tdest;
  logic cfg_wr_en, cfg_valid;
  logic [AW-1:0] cfg_addr;
  logic [FW-1:0] cfg_match, cfg_mask;
  logic [DESTW-1:0] cfg_dest;

  axis_dest_tagger dut (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
    .m_axis_tdest(m_axis_tdest),
    .cfg_wr_en(cfg_wr_en), .cfg_addr(cfg_addr), .cfg_valid(cfg_valid),
    .cfg_match(cfg_match), .cfg_mask(cfg_mask), .cfg_dest(cfg_dest)
  );

  typedef struct {
    logic [DW-1:0]    data;
    logic [KW-1:0]    keep;
    logic             last;
    logic [UW-1:0]    user;
    logic [DESTW-1:0] dest;
  } beat_t;

  beat_t exp_q[$];
  int checks = 0, errors = 0;
  int cyc = 0;
  bit rand_rdy = 0;

  // Reference model: rule table and frame tracking
  bit               r_vld   [RC];
  logic [FW-1:0]    r_match [RC];
  logic [FW-1:0]    r_mask  [RC];
  logic [DESTW-1:0] r_dest  [RC];
  bit               mdl_in_frame = 0;
  logic [DESTW-1:0] mdl_frame_dest = '0;

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    if (rand_rdy) m_axis_tready = 1'($urandom_range(0, 1));
  end

  task automatic check(input string name, input logic [599:0] act, input logic [599:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [DESTW-1:0] model_lookup(input logic [FW-1:0] f);
    for (int i = 0; i < RC; i++)
      if (r_vld[i] && ((f & r_mask[i]) == (r_match[i] & r_mask[i]))) return r_dest[i];
    return DESTW'(0);
  endfunction

  task automatic model_accept(input beat_t b);
    beat_t e;
    e = b;
    if (!mdl_in_frame) mdl_frame_dest = model_lookup(b.data[FO +: FW]);
    e.dest = mdl_frame_dest;
    mdl_in_frame = !b.last;
    exp_q.push_back(e);
  endtask

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] d;
    for (int i = 0; i < DW/32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  task automatic cfg_drive(input int a, input bit v, input logic [FW-1:0] m, input logic [FW-1:0] k,
                           input logic [DESTW-1:0] d);
    cfg_wr_en = 1'b1; cfg_addr = AW'(a); cfg_valid = v; cfg_match = m; cfg_mask = k; cfg_dest = d;
  endtask

  task automatic cfg_model(input int a, input bit v, input logic [FW-1:0] m, input logic [FW-1:0] k,
                           input logic [DESTW-1:0] d);
    if (a < RC) begin
      r_vld[a] = v; r_match[a] = m; r_mask[a] = k; r_dest[a] = d;
    end
    cfg_wr_en = 1'b0;
  endtask

  task automatic cfg_write(input int a, input bit v, input logic [FW-1:0] m, input logic [FW-1:0] k,
                           input logic [DESTW-1:0] d);
    cfg_drive(a, v, m, k, d);
    @(posedge clk); #1;
    cfg_model(a, v, m, k, d);
  endtask

  // Presents one beat (optionally with a same-cycle rule write) and waits for it to be accepted.
  task automatic send_beat(input logic [FW-1:0] f, input bit last, input bit cfg, input int ca, input bit cv,
                           input logic [FW-1:0] cm, input logic [FW-1:0] ck, input logic [DESTW-1:0] cd);
    beat_t b;
    bit done, pend;
    done = 0;
    pend = cfg;
    b.data = rand_data();
    b.data[FO +: FW] = f;
    b.keep = {$urandom, $urandom};
    b.last = last;
    b.user = UW'($urandom);
    b.dest = '0;
    s_axis_tdata = b.data; s_axis_tkeep = b.keep; s_axis_tlast = b.last; s_axis_tuser = b.user;
    s_axis_tvalid = 1'b1;
    if (cfg) cfg_drive(ca, cv, cm, ck, cd);
    for (int n = 0; n < 1000 && !done; n++) begin
      @(negedge clk);
      if (s_axis_tready) begin
        model_accept(b);
        done = 1;
      end
      @(posedge clk); #1;
      if (pend) begin
        cfg_model(ca, cv, cm, ck, cd);
        pend = 0;
      end
    end
    s_axis_tvalid = 1'b0;
    if (!done) begin
      checks++; errors++;
      $display("FAIL accept_timeout: beat not accepted within 1000 cycles");
    end
  endtask

  task automatic beat(input logic [FW-1:0] f, input bit last);
    send_beat(f, last, 0, 0, 0, '0, '0, '0);
  endtask

  // Monitor: pops and compares on every output handshake; checks hold stability under backpressure.
  beat_t hold;
  bit hold_vld = 0;
  always @(negedge clk) begin
    beat_t e;
    if (!rst_n) hold_vld = 0;
    else begin
      if (hold_vld) begin
        check("tvalid_held", 600'(m_axis_tvalid), 600'(1));
        check("stall_stable", 600'({m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser, m_axis_tdest}),
              600'({hold.data, hold.keep, hold.last, hold.user, hold.dest}));
      end
      hold_vld = 0;
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_beat: output beat seen, scoreboard empty");
        end else begin
          e = exp_q.pop_front();
          check("payload", 600'({m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser}),
                600'({e.data, e.keep, e.last, e.user}));
          check("tdest", 600'(m_axis_tdest), 600'(e.dest));
        end
      end else if (m_axis_tvalid) begin
        hold.data = m_axis_tdata; hold.keep = m_axis_tkeep; hold.last = m_axis_tlast;
        hold.user = m_axis_tuser; hold.dest = m_axis_tdest;
        hold_vld = 1;
      end
    end
  end

  task automatic drain();
    for (int n = 0; n < 200 && exp_q.size() > 0; n++) begin
      @(posedge clk); #1;
    end
    check("drained", 600'(exp_q.size()), 600'(0));
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, len;
    logic [FW-1:0] fsel [4];
    logic [FW-1:0] msel [4];
    fsel[0] = 16'h0800; fsel[1] = 16'h86DD; fsel[2] = 16'h0801; fsel[3] = 16'h1234;
    msel[0] = 16'hFFFF; msel[1] = 16'hFF00; msel[2] = 16'h0000; msel[3] = 16'h00FF;
    for (int i = 0; i < RC; i++) begin
      r_vld[i] = 0; r_match[i] = '0; r_mask[i] = '0; r_dest[i] = '0;
    end
    rst_n = 1'b0; m_axis_tready = 1'b1;
    s_axis_tvalid = 1'b0; s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tlast = 1'b0; s_axis_tuser = '0;
    cfg_wr_en = 1'b0; cfg_addr = '0; cfg_valid = 1'b0; cfg_match = '0; cfg_mask = '0; cfg_dest = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tvalid", 600'(m_axis_tvalid), 600'(0));
    check("rst_tready", 600'(s_axis_tready), 600'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("ready_after_rst", 600'(s_axis_tready), 600'(1));
    check("tvalid_after_rst", 600'(m_axis_tvalid), 600'(0));

    // 1: exact-match rule, 3-beat frame, one-cycle latency
    cfg_write(0, 1, 16'h0800, 16'hFFFF, 2'd2);
    beat(16'h0800, 0);
    check("latency_tvalid", 600'(m_axis_tvalid), 600'(1));
    check("latency_tdest", 600'(m_axis_tdest), 600'(2));
    beat(16'h1111, 0);
    beat(16'h2222, 1);
    repeat (3) @(posedge clk);
    #1;

    // 2: no rules, back-to-back single-beat frames at full rate
    cfg_write(0, 0, 16'h0800, 16'hFFFF, 2'd2);
    c0 = cyc;
    for (int i = 0; i < 8; i++) beat(fsel[i % 4], 1);
    check("full_rate_cycles", 600'(cyc - c0), 600'(8));
    // each single-beat frame is looked up afresh
    cfg_write(0, 1, 16'h0800, 16'hFFFF, 2'd2);
    for (int i = 0; i < 6; i++) beat(fsel[i % 2 * 3], 1);

    // 3: two hitting rules, lowest index wins; catch-all rule3
    cfg_write(1, 1, 16'h86DD, 16'hFFFF, 2'd1);
    cfg_write(3, 1, 16'h0000, 16'h0000, 2'd3);
    beat(16'h86DD, 0); beat(16'h0800, 1);
    beat(16'h4321, 0); beat(16'h86DD, 1);

    // 4: rewrite during a frame, then a rewrite coinciding with a first beat
    beat(16'h0800, 0);
    send_beat(16'h0000, 0, 1, 0, 1, 16'h0800, 16'hFFFF, 2'd3);
    beat(16'h0000, 0); beat(16'h0000, 1);
    beat(16'h0800, 1);
    send_beat(16'h0800, 1, 1, 0, 1, 16'h0800, 16'hFFFF, 2'd1);
    beat(16'h0800, 1);
    drain();

    // 5: random frames, random backpressure, bubbles and rule rewrites
    rand_rdy = 1;
    for (int fr = 0; fr < 1000; fr++) begin
      len = $urandom_range(1, 4);
      for (int b = 0; b < len; b++) begin
        if ($urandom_range(0, 19) == 0)
          send_beat(fsel[$urandom_range(0, 3)], b == len - 1, 1, $urandom_range(0, RC - 1),
                    1'($urandom_range(0, 1)), fsel[$urandom_range(0, 3)], msel[$urandom_range(0, 3)],
                    DESTW'($urandom));
        else
          beat(($urandom_range(0, 3) == 0) ? FW'($urandom) : fsel[$urandom_range(0, 3)], b == len - 1);
        if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) @(posedge clk);
        #0;
      end
    end
    rand_rdy = 0;
    @(posedge clk); #2;
    m_axis_tready = 1'b1;
    drain();

    // 6: reset mid-frame with the skid full
    cfg_write(0, 1, 16'h0800, 16'hFFFF, 2'd2);
    cfg_write(1, 0, 16'h0000, 16'h0000, 2'd0);
    cfg_write(2, 0, 16'h0000, 16'h0000, 2'd0);
    cfg_write(3, 0, 16'h0000, 16'h0000, 2'd0);
    m_axis_tready = 1'b0;
    beat(16'h1234, 0);
    beat(16'h0800, 0);
    @(negedge clk);
    check("skid_full_ready", 600'(s_axis_tready), 600'(0));
    @(posedge clk); #1;
    rst_n = 1'b0;
    exp_q.delete();
    mdl_in_frame = 0;
    for (int i = 0; i < RC; i++) r_vld[i] = 0;
    @(posedge clk); #1;
    check("rst_mid_tvalid", 600'(m_axis_tvalid), 600'(0));
    rst_n = 1'b1;
    m_axis_tready = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_ready", 600'(s_axis_tready), 600'(1));
    beat(16'h0800, 1);
    cfg_write(0, 1, 16'h0800, 16'hFFFF, 2'd2);
    beat(16'h0800, 0); beat(16'h0000, 1);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
